// File: rtl/hilo_muldiv.sv
// hilo_muldiv: HI/LO register pair with an iterative multiply/divide unit.
// MULT/DIV run one shift-add or restoring shift-subtract step per cycle on
// operand magnitudes. The sign of the result is applied when HI/LO are written.
// MTHI/MTLO load HI or LO directly in a single cycle.
module hilo_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             sign,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_MTHI = 2'b10;
  localparam logic [1:0] OP_MTLO = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIN  = 2'b10
  } stateT;

  stateT state;
  stateT stateNext;

  // Control strobes decoded from the current state and the request inputs.
  logic acceptMove;
  logic acceptCalc;
  logic acceptZeroDiv;

  // Working registers, shared between multiply and divide.
  //   MULT: workHi holds the running upper product half, and workLo holds
  //         the multiplier being shifted out / the lower product half.
  //   DIV:  workHi holds the partial remainder, and workLo holds the
  //         dividend being shifted out / the quotient being shifted in.
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] workHi;
  logic [WIDTH-1:0] workLo;
  logic [WIDTH-1:0] operand;   // multiplicand (MULT) or divisor (DIV) magnitude
  logic             isDiv;
  logic             zeroDiv;
  logic             negRes;    // negate product / quotient
  logic             negRem;    // negate remainder (follows the dividend sign)

  // Operand magnitudes at acceptance.
  logic [WIDTH-1:0] magA;
  logic [WIDTH-1:0] magB;

  // One-step results for each iteration kind.
  logic [WIDTH:0]   mulSum;
  logic [WIDTH-1:0] mulHi;
  logic [WIDTH-1:0] mulLo;
  logic [WIDTH:0]   divShift;
  logic [WIDTH:0]   divTrial;
  logic [WIDTH-1:0] divHi;
  logic [WIDTH-1:0] divLo;

  // Final signed results.
  logic [2*WIDTH-1:0] prodMag;
  logic [2*WIDTH-1:0] prodRes;
  logic [WIDTH-1:0]   quoRes;
  logic [WIDTH-1:0]   remRes;

  assign magA = (sign && A[WIDTH-1]) ? (~A + 1'b1) : A;
  assign magB = (sign && B[WIDTH-1]) ? (~B + 1'b1) : B;

  // Shift-add step: conditionally add the multiplicand, then shift right one bit.
  assign mulSum = {1'b0, workHi} + (workLo[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
  assign mulHi  = mulSum[WIDTH:1];
  assign mulLo  = {mulSum[0], workLo[WIDTH-1:1]};

  // Restoring step: shift in the next dividend bit and keep the difference if it is non-negative.
  assign divShift = {workHi, workLo[WIDTH-1]};
  assign divTrial = divShift - {1'b0, operand};
  assign divHi    = divTrial[WIDTH] ? divShift[WIDTH-1:0] : divTrial[WIDTH-1:0];
  assign divLo    = {workLo[WIDTH-2:0], ~divTrial[WIDTH]};

  assign prodMag = {workHi, workLo};
  assign prodRes = negRes ? (~prodMag + 1'b1) : prodMag;
  assign quoRes  = negRes ? (~workLo + 1'b1) : workLo;
  assign remRes  = negRem ? (~workHi + 1'b1) : workHi;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic and acceptance decoding; a start is only sampled in IDLE.
  always_comb begin
    stateNext     = state;
    acceptMove    = 1'b0;
    acceptCalc    = 1'b0;
    acceptZeroDiv = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          case (op)
            OP_MULT: begin
              acceptCalc = 1'b1;
              stateNext  = CALC;
            end
            OP_DIV: begin
              if (B == '0) begin
                acceptZeroDiv = 1'b1;
                stateNext     = FIN;
              end else begin
                acceptCalc = 1'b1;
                stateNext  = CALC;
              end
            end
            default: begin
              acceptMove = 1'b1;
            end
          endcase
        end
      end
      CALC: begin
        if (count == LAST_ITER) begin
          stateNext = FIN;
        end
      end
      FIN: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Datapath: operand capture, per-cycle iteration, HI/LO writeback and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi          <= '0;
      lo          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      count       <= '0;
      workHi      <= '0;
      workLo      <= '0;
      operand     <= '0;
      isDiv       <= 1'b0;
      zeroDiv     <= 1'b0;
      negRes      <= 1'b0;
      negRem      <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;

      if (acceptMove) begin
        if (op == OP_MTHI) begin
          hi <= A;
        end else begin
          lo <= A;
        end
        done <= 1'b1;
      end

      if (acceptCalc) begin
        busy    <= 1'b1;
        count   <= '0;
        isDiv   <= (op == OP_DIV);
        zeroDiv <= 1'b0;
        negRes  <= sign & (A[WIDTH-1] ^ B[WIDTH-1]);
        negRem  <= sign & A[WIDTH-1];
        workHi  <= '0;
        if (op == OP_DIV) begin
          operand <= magB;
          workLo  <= magA;
        end else begin
          operand <= magA;
          workLo  <= magB;
        end
      end

      if (acceptZeroDiv) begin
        isDiv   <= 1'b1;
        zeroDiv <= 1'b1;
      end

      if (state == CALC) begin
        count <= count + CNT_W'(1);
        if (isDiv) begin
          workHi <= divHi;
          workLo <= divLo;
        end else begin
          workHi <= mulHi;
          workLo <= mulLo;
        end
      end

      if (state == FIN) begin
        busy <= 1'b0;
        done <= 1'b1;
        if (zeroDiv) begin
          div_by_zero <= 1'b1;
        end else if (isDiv) begin
          hi <= remRes;
          lo <= quoRes;
        end else begin
          hi <= prodRes[2*WIDTH-1:WIDTH];
          lo <= prodRes[WIDTH-1:0];
        end
      end
    end
  end

endmodule

// File: doc/hilo_muldiv.md
HILO_MULDIV -- requirements
Module: hilo_muldiv

Interface
- REQ-001: Parameter WIDTH, default 32, sets operand, HI and LO width.
- REQ-002: clk  input  1  single clock; all state updates on its rising edge.
- REQ-003: rst_n  input  1  reset, asynchronous, active-low.
- REQ-004: start  input  1  request strobe; sampled only in IDLE.
- REQ-005: op  input  2  00 MULT, 01 DIV, 10 MTHI, 11 MTLO.
- REQ-006: sign  input  1  1 = signed (two's complement) operands, 0 = unsigned.
- REQ-007: A  input  WIDTH  multiplicand, dividend, or move source.
- REQ-008: B  input  WIDTH  multiplier or divisor; ignored for MTHI/MTLO.
- REQ-009: hi  output  WIDTH  HI register, readable every cycle (MFHI path).
- REQ-010: lo  output  WIDTH  LO register, readable every cycle (MFLO path).
- REQ-011: busy  output  1  high while an iterative MULT/DIV is in progress.
- REQ-012: done  output  1  one-cycle pulse on completion of any accepted operation.
- REQ-013: div_by_zero  output  1  one-cycle pulse coincident with done for a DIV with B == 0.

Function
- REQ-014: FSM states are IDLE, CALC, and FIN; the block leaves reset in IDLE.
- REQ-015: An operation is accepted at a rising edge E0 when state is IDLE and start = 1; A, B, op and sign are captured at E0 and later input changes have no effect.
- REQ-016: start while busy = 1 or state != IDLE is ignored (no queueing).
- REQ-017: MTHI/MTLO: at E0 hi (resp. lo) <= A, other register unchanged; done = 1 for the cycle after E0; busy stays 0; state stays IDLE.
- REQ-018: MULT/DIV with B != 0 (or MULT with any B): E0 -> CALC with a 6-bit counter = 0 and busy = 1 from E0.
- REQ-019: In CALC, one iteration per cycle (shift-add for MULT, restoring shift-subtract for DIV) on operand magnitudes; after 32 iterations (edges E1..E32) the FSM goes to FIN.
- REQ-020: At E33 (FIN): hi/lo are written, busy <= 0, done <= 1 for exactly one cycle, and the FSM goes to IDLE; a start sampled at E34 is accepted.
- REQ-021: MULT: {hi,lo} = full 2*WIDTH-bit product; signed: product negated when A[31] ^ B[31].
- REQ-022: DIV: lo = quotient, hi = remainder; signed: quotient negated when A[31] ^ B[31], remainder takes the sign of A; quotient truncates toward zero.
- REQ-023: Signed DIV 0x80000000 / 0xFFFFFFFF yields lo = 0x80000000, hi = 0 with no error flag.
- REQ-024: DIV with B == 0: no CALC; at E0 the FSM goes to FIN, done and div_by_zero are high for the cycle after E1, and hi/lo are unchanged.
- REQ-025: hi/lo never show intermediate values; they change only at E0 (moves) or at the FIN edge.
- REQ-026: done and div_by_zero are registered outputs, never combinational from start.

Reset
- REQ-027: When rst_n = 0: state IDLE; hi = lo = 0; busy = done = div_by_zero = 0; counter and working registers cleared; takes effect immediately without waiting for a clock edge.
- REQ-028: Reset asserted mid-CALC aborts the operation with no done pulse; the first start after rst_n rises is accepted normally.

Verification
- REQ-029: Unsigned MULT A=0xFFFFFFFF, B=2 -> done 33 cycles after E0; hi=0x00000001, lo=0xFFFFFFFE; busy high for exactly 33 cycles.
- REQ-030: Signed MULT A=0xFFFFFFFD (-3), B=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- REQ-031: Signed DIV A=0xFFFFFFF9 (-7), B=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; unsigned DIV A=100, B=7 -> lo=14, hi=2.
- REQ-032: DIV by zero with hi=0x11, lo=0x22 preloaded via MTHI/MTLO -> done and div_by_zero pulse together after E1; hi=0x11, lo=0x22 retained.
- REQ-033: MULT started, then start with op=MTHI and A=0x5 pulsed at cycle 10 -> ignored; final hi/lo equal the product; exactly one done pulse.
- REQ-034: rst_n low at cycle 15 of a MULT -> hi=lo=0, busy=0 immediately; no done; the next MULT completes correctly.
